// File: rtl/hazard_controller.sv
// Hazard controller for the 5-stage RV32I pipeline: shadows EX/MEM/WB register usage
// and derives operand forwarding, load-use stalls, branch flushes and the dmem freeze.
module hazard_controller #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             id_valid,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic [4:0]       id_rd,
    input  logic             id_regwrite,
    input  logic             id_memread,
    input  logic             id_memwrite,
    input  logic             branch_taken,
    input  logic             dmem_ready,
    output logic [1:0]       forward_a,
    output logic [1:0]       forward_b,
    output logic             stall_if_id,
    output logic             bubble_ex,
    output logic             flush_if_id,
    output logic             freeze,
    output logic [CNT_W-1:0] hazard_cycles
);

    typedef struct packed {
        logic       valid;
        logic [4:0] rd;
        logic       regwrite;
        logic       memread;
        logic       memwrite;
    } stage_t;

    typedef struct packed {
        stage_t     s;
        logic [4:0] rs1;
        logic [4:0] rs2;
    } ex_stage_t;

    localparam logic [1:0] FWD_REGFILE = 2'b00;
    localparam logic [1:0] FWD_EXMEM   = 2'b10;
    localparam logic [1:0] FWD_MEMWB   = 2'b01;

    ex_stage_t        r_ex;
    stage_t           r_mem;
    stage_t           r_wb;
    logic [CNT_W-1:0] r_cnt;

    ex_stage_t w_id_ex;
    logic      w_mem_op;
    logic      w_freeze;
    logic      w_branch;
    logic      w_load_use;
    logic      w_any_hazard;

    function automatic logic qualified(input stage_t st);
        return st.valid && st.regwrite && (st.rd != 5'd0);
    endfunction

    // MEM holds the younger result, so it wins over WB for the same register.
    function automatic logic [1:0] fwd_sel(input logic [4:0] rs, input logic ex_valid,
                                           input stage_t mem, input stage_t wb);
        if (!ex_valid)                          return FWD_REGFILE;
        else if (qualified(mem) && mem.rd == rs) return FWD_EXMEM;
        else if (qualified(wb) && wb.rd == rs)   return FWD_MEMWB;
        else                                     return FWD_REGFILE;
    endfunction

    always_comb begin
        w_id_ex.s.valid    = id_valid;
        w_id_ex.s.rd       = id_rd;
        w_id_ex.s.regwrite = id_regwrite;
        w_id_ex.s.memread  = id_memread;
        w_id_ex.s.memwrite = id_memwrite;
        w_id_ex.rs1        = id_rs1;
        w_id_ex.rs2        = id_rs2;
    end

    // dmem_ready only matters while MEM actually holds a load or store.
    assign w_mem_op     = r_mem.valid && (r_mem.memread || r_mem.memwrite);
    assign w_freeze     = w_mem_op && !dmem_ready;
    assign w_branch     = branch_taken && r_ex.s.valid && !w_freeze;
    assign w_load_use   = !w_freeze && !w_branch && id_valid && r_ex.s.valid &&
                          r_ex.s.memread && (r_ex.s.rd != 5'd0) &&
                          ((r_ex.s.rd == id_rs1) || (r_ex.s.rd == id_rs2));
    assign w_any_hazard = w_freeze || w_branch || w_load_use;

    assign forward_a     = fwd_sel(r_ex.rs1, r_ex.s.valid, r_mem, r_wb);
    assign forward_b     = fwd_sel(r_ex.rs2, r_ex.s.valid, r_mem, r_wb);
    assign freeze        = w_freeze;
    assign flush_if_id   = w_branch;
    assign stall_if_id   = w_load_use;
    assign bubble_ex     = w_branch || w_load_use;
    assign hazard_cycles = r_cnt;

    // NOTE: state uses non-blocking assignments so every stage samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ex  <= '0;
            r_mem <= '0;
            r_wb  <= '0;
        end else if (!w_freeze) begin
            r_ex  <= (w_branch || w_load_use) ? '0 : w_id_ex;
            r_mem <= r_ex.s;
            r_wb  <= r_mem;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (w_any_hazard && (r_cnt != '1)) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_hazard_controller.sv
// Directed bench for hazard_controller: a cycle-by-cycle vector table plus
// hand-written reset-during-freeze and counter-saturation checks.
module tb_hazard_controller;

    logic        clk = 1'b0;
    logic        reset;
    logic        id_valid;
    logic [4:0]  id_rs1, id_rs2, id_rd;
    logic        id_regwrite, id_memread, id_memwrite;
    logic        branch_taken, dmem_ready;
    logic [1:0]  forward_a, forward_b;
    logic        stall_if_id, bubble_ex, flush_if_id, freeze;
    logic [15:0] hazard_cycles;

    logic [1:0]  s_forward_a, s_forward_b;
    logic        s_stall_if_id, s_bubble_ex, s_flush_if_id, s_freeze;
    logic [1:0]  s_hazard_cycles;

    int n_tests = 0;
    int n_fail  = 0;

    hazard_controller #(.CNT_W(16)) dut (
        .clk(clk), .reset(reset),
        .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
        .id_regwrite(id_regwrite), .id_memread(id_memread), .id_memwrite(id_memwrite),
        .branch_taken(branch_taken), .dmem_ready(dmem_ready),
        .forward_a(forward_a), .forward_b(forward_b),
        .stall_if_id(stall_if_id), .bubble_ex(bubble_ex),
        .flush_if_id(flush_if_id), .freeze(freeze),
        .hazard_cycles(hazard_cycles)
    );

    // Narrow counter instance sharing the same stimulus, used to observe saturation.
    hazard_controller #(.CNT_W(2)) dut_sat (
        .clk(clk), .reset(reset),
        .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
        .id_regwrite(id_regwrite), .id_memread(id_memread), .id_memwrite(id_memwrite),
        .branch_taken(branch_taken), .dmem_ready(dmem_ready),
        .forward_a(s_forward_a), .forward_b(s_forward_b),
        .stall_if_id(s_stall_if_id), .bubble_ex(s_bubble_ex),
        .flush_if_id(s_flush_if_id), .freeze(s_freeze),
        .hazard_cycles(s_hazard_cycles)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        idv;
        logic [4:0]  rs1, rs2, rd;
        logic        rw, mr, mw, br, rdy;
        logic [1:0]  fa, fb;
        logic        st, bub, fl, fz;
        logic [15:0] hc;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t v(input logic idv, input logic [4:0] rs1, input logic [4:0] rs2,
                               input logic [4:0] rd, input logic rw, input logic mr,
                               input logic mw, input logic br, input logic rdy,
                               input logic [1:0] fa, input logic [1:0] fb, input logic st,
                               input logic bub, input logic fl, input logic fz,
                               input logic [15:0] hc);
        vec_t r;
        r.idv = idv; r.rs1 = rs1; r.rs2 = rs2; r.rd = rd;
        r.rw = rw; r.mr = mr; r.mw = mw; r.br = br; r.rdy = rdy;
        r.fa = fa; r.fb = fb; r.st = st; r.bub = bub; r.fl = fl; r.fz = fz; r.hc = hc;
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic [1:0] fa, input logic [1:0] fb,
                             input logic st, input logic bub, input logic fl, input logic fz,
                             input logic [15:0] hc);
        check({tag, " forward_a"}, 32'(forward_a), 32'(fa));
        check({tag, " forward_b"}, 32'(forward_b), 32'(fb));
        check({tag, " stall_if_id"}, 32'(stall_if_id), 32'(st));
        check({tag, " bubble_ex"}, 32'(bubble_ex), 32'(bub));
        check({tag, " flush_if_id"}, 32'(flush_if_id), 32'(fl));
        check({tag, " freeze"}, 32'(freeze), 32'(fz));
        check({tag, " hazard_cycles"}, 32'(hazard_cycles), 32'(hc));
    endtask

    task automatic drive(input logic idv, input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic [4:0] rd, input logic rw, input logic mr, input logic mw,
                         input logic br, input logic rdy);
        id_valid = idv; id_rs1 = rs1; id_rs2 = rs2; id_rd = rd;
        id_regwrite = rw; id_memread = mr; id_memwrite = mw;
        branch_taken = br; dmem_ready = rdy;
    endtask

    task automatic drive_idle();
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    initial begin
        //                 idv rs1 rs2 rd  rw mr mw br rdy  fa     fb     st bub fl fz hc
        // Back-to-back ALU dependency on x5
        vecs.push_back(v(1, 1,  2,  5,  1, 0, 0, 0, 1,  2'b00, 2'b00, 0, 0, 0, 0, 0));
        vecs.push_back(v(1, 5,  6,  8,  1, 0, 0, 0, 1,  2'b00, 2'b00, 0, 0, 0, 0, 0));
        vecs.push_back(v(1, 9,  5,  10, 1, 0, 0, 0, 0,  2'b10, 2'b00, 0, 0, 0, 0, 0));
        vecs.push_back(v(0, 0,  0,  0,  0, 0, 0, 0, 1,  2'b00, 2'b01, 0, 0, 0, 0, 0));
        // Double producer of x7
        vecs.push_back(v(1, 0,  0,  7,  1, 0, 0, 0, 1,  2'b00, 2'b00, 0, 0, 0, 0, 0));
        vecs.push_back(v(1, 0,  0,  7,  1, 0, 0, 0, 1,  2'b00, 2'b00, 0, 0, 0, 0, 0));
        vecs.push_back(v(1, 7,  7,  11, 1, 0, 0, 0, 1,  2'b00, 2'b00, 0, 0, 0, 0, 0));
        vecs.push_back(v(0, 0,  0,  0,  0, 0, 0, 0, 1,  2'b10, 2'b10, 0, 0, 0, 0, 0));
        // Producer with rd=0 must never forward
        vecs.push_back(v(1, 0,  0,  0,  1, 0, 0, 0, 1,  2'b00, 2'b00, 0, 0, 0, 0, 0));
        vecs.push_back(v(1, 0,  0,  12, 1, 0, 0, 0, 1,  2'b00, 2'b00, 0, 0, 0, 0, 0));
        vecs.push_back(v(0, 0,  0,  0,  0, 0, 0, 0, 1,  2'b00, 2'b00, 0, 0, 0, 0, 0));
        vecs.push_back(v(0, 0,  0,  0,  0, 0, 0, 0, 1,  2'b00, 2'b00, 0, 0, 0, 0, 0));
        // Load-use: lw x3 then add rs2=3 (held in ID for the stall cycle)
        vecs.push_back(v(1, 1,  0,  3,  1, 1, 0, 0, 1,  2'b00, 2'b00, 0, 0, 0, 0, 0));
        vecs.push_back(v(1, 4,  3,  13, 1, 0, 0, 0, 1,  2'b00, 2'b00, 1, 1, 0, 0, 0));
        vecs.push_back(v(1, 4,  3,  13, 1, 0, 0, 0, 1,  2'b00, 2'b00, 0, 0, 0, 0, 1));
        vecs.push_back(v(0, 0,  0,  0,  0, 0, 0, 0, 1,  2'b00, 2'b01, 0, 0, 0, 0, 1));
        // Branch taken with a simultaneous load-use match: flush wins
        vecs.push_back(v(1, 1,  0,  6,  1, 1, 0, 0, 1,  2'b00, 2'b00, 0, 0, 0, 0, 1));
        vecs.push_back(v(1, 6,  0,  14, 1, 0, 0, 1, 1,  2'b00, 2'b00, 0, 1, 1, 0, 1));
        vecs.push_back(v(0, 0,  0,  0,  0, 0, 0, 0, 1,  2'b00, 2'b00, 0, 0, 0, 0, 2));
        // Freeze: load in MEM, dmem_ready low 3 cycles, branch pending throughout
        vecs.push_back(v(1, 0,  0,  20, 1, 0, 0, 0, 1,  2'b00, 2'b00, 0, 0, 0, 0, 2));
        vecs.push_back(v(1, 1,  0,  9,  1, 1, 0, 0, 1,  2'b00, 2'b00, 0, 0, 0, 0, 2));
        vecs.push_back(v(1, 1,  20, 15, 1, 0, 0, 0, 1,  2'b00, 2'b00, 0, 0, 0, 0, 2));
        vecs.push_back(v(1, 0,  0,  16, 1, 0, 0, 1, 0,  2'b00, 2'b01, 0, 0, 0, 1, 2));
        vecs.push_back(v(1, 0,  0,  16, 1, 0, 0, 1, 0,  2'b00, 2'b01, 0, 0, 0, 1, 3));
        vecs.push_back(v(1, 0,  0,  16, 1, 0, 0, 1, 0,  2'b00, 2'b01, 0, 0, 0, 1, 4));
        vecs.push_back(v(1, 0,  0,  16, 1, 0, 0, 1, 1,  2'b00, 2'b01, 0, 1, 1, 0, 5));
        vecs.push_back(v(0, 0,  0,  0,  0, 0, 0, 0, 1,  2'b00, 2'b00, 0, 0, 0, 0, 6));

        // Reset held with hazard-looking inputs: everything stays 0.
        reset = 1'b1;
        drive(1'b1, 5'd3, 5'd3, 5'd3, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        #1;
        check_all("reset", 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0);
        @(posedge clk);
        #1;
        check_all("reset_edge", 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0);
        drive_idle();
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;

        foreach (vecs[i]) begin
            drive(vecs[i].idv, vecs[i].rs1, vecs[i].rs2, vecs[i].rd, vecs[i].rw,
                  vecs[i].mr, vecs[i].mw, vecs[i].br, vecs[i].rdy);
            @(negedge clk);
            check_all($sformatf("v%0d", i), vecs[i].fa, vecs[i].fb, vecs[i].st,
                      vecs[i].bub, vecs[i].fl, vecs[i].fz, vecs[i].hc);
            @(posedge clk);
            #1;
        end

        // Six hazard cycles so far: the 2-bit counter must sit at all-ones.
        check("sat hazard_cycles", 32'(s_hazard_cycles), 32'd3);

        // Set up a freeze with live forwarding, then hit reset mid-cycle.
        drive(1'b1, 5'd0, 5'd0, 5'd21, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        @(posedge clk); #1;
        drive(1'b1, 5'd1, 5'd0, 5'd22, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        @(posedge clk); #1;
        drive(1'b1, 5'd21, 5'd0, 5'd23, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        @(posedge clk); #1;
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        @(negedge clk);
        check_all("pre_reset_freeze", 2'b01, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 16'd6);
        #2;
        reset = 1'b1;
        #1;
        check_all("async_reset", 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0);
        check("async_reset sat hazard_cycles", 32'(s_hazard_cycles), 32'd0);
        @(posedge clk); #1;
        drive_idle();
        @(negedge clk);
        reset = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            check_all($sformatf("post_reset%0d", k), 2'b00, 2'b00, 1'b0, 1'b0, 1'b0,
                      1'b0, 16'd0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
